// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: forwarding-select codes and multi-cycle FSM states shared by the hazard controller
package pipe_ctrl_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;
  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-register fields in (ID/EX/MEM/WB), enables/forward selects/counters out; master=pipeline, slave=controller
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_branch, id_jr, id_jump, id_taken;
  logic ex_regwrite, ex_memread, ex_mcyc, mem_regwrite, mem_memread, wb_regwrite;
  logic pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_en, ex_mem_bubble, mcyc_busy;
  logic [1:0] forward_a, forward_b;
  logic fwd_id_a, fwd_id_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           id_use_rs, id_use_rt, id_branch, id_jr, id_jump, id_taken,
           ex_regwrite, ex_memread, ex_mcyc, mem_regwrite, mem_memread, wb_regwrite,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_en, ex_mem_bubble, mcyc_busy,
           forward_a, forward_b, fwd_id_a, fwd_id_b, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
           id_use_rs, id_use_rt, id_branch, id_jr, id_jump, id_taken,
           ex_regwrite, ex_memread, ex_mcyc, mem_regwrite, mem_memread, wb_regwrite,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_en, ex_mem_bubble, mcyc_busy,
           forward_a, forward_b, fwd_id_a, fwd_id_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones; clk, rst (async), inc, clr in; q out
module sat_counter #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/forward/flush/multi-cycle-hold control for a 5-stage MIPS pipeline; clk, rst (async) plus the slave side of pipe_hazard_ctrl_if
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MCYC_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave p
);
  localparam int CW = MCYC_LAT > 2 ? $clog2(MCYC_LAT) : 1;
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] src, input logic mw,
      input logic [REG_AW-1:0] mrd, input logic ww, input logic [REG_AW-1:0] wrd);
    return (mw && mrd != '0 && mrd == src) ? FWD_EXMEM :
           (ww && wrd != '0 && wrd == src) ? FWD_WB : FWD_REG;
  endfunction
  function automatic logic hit(input logic [REG_AW-1:0] src, input logic used,
      input logic [REG_AW-1:0] rd);
    return used && src != '0 && src == rd;
  endfunction
  mc_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic id_cmp, use_a, use_b, hz, hold, last, flush_req;
  // jr reads rs in ID even if the decoder does not flag it as an rs user
  assign id_cmp = p.id_branch | p.id_jr;
  assign use_a  = p.id_use_rs | p.id_jr;
  assign use_b  = p.id_use_rt;
  assign hz = (p.ex_memread && (hit(p.id_rs, use_a, p.ex_rd) || hit(p.id_rt, use_b, p.ex_rd))) ||
              (id_cmp && p.ex_regwrite && (hit(p.id_rs, use_a, p.ex_rd) || hit(p.id_rt, use_b, p.ex_rd))) ||
              (id_cmp && p.mem_memread && (hit(p.id_rs, use_a, p.mem_rd) || hit(p.id_rt, use_b, p.mem_rd)));
  assign flush_req = p.id_jump || (p.id_branch && p.id_taken) || p.id_jr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    hold    = (state == MC_IDLE && p.ex_mcyc) || state == MC_BUSY;
    last    = state == MC_BUSY && cnt == '0;
    state_n = state == MC_IDLE ? (p.ex_mcyc ? MC_BUSY : MC_IDLE) : (last ? MC_IDLE : MC_BUSY);
    cnt_n   = state == MC_IDLE ? (p.ex_mcyc ? CW'(MCYC_LAT - 2) : cnt) : (last ? cnt : cnt - 1'b1);
    p.pc_en         = !(hold || hz);
    p.if_id_en      = !(hold || hz);
    p.id_ex_en      = !hold;
    p.id_ex_bubble  = !hold && hz;
    p.if_id_flush   = !hold && !hz && flush_req;
    p.ex_mem_bubble = hold && !last;
    p.mcyc_busy     = state == MC_BUSY;
    p.forward_a     = fwd(p.ex_rs, p.mem_regwrite, p.mem_rd, p.wb_regwrite, p.wb_rd);
    p.forward_b     = fwd(p.ex_rt, p.mem_regwrite, p.mem_rd, p.wb_regwrite, p.wb_rd);
    p.fwd_id_a      = id_cmp && p.mem_regwrite && !p.mem_memread && p.mem_rd != '0 && p.mem_rd == p.id_rs;
    p.fwd_id_b      = id_cmp && p.mem_regwrite && !p.mem_memread && p.mem_rd != '0 && p.mem_rd == p.id_rt;
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(!p.pc_en), .clr(1'b0), .q(p.stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(p.if_id_flush), .clr(1'b0), .q(p.flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, stalls, flushes, multi-cycle hold and counter saturation
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2)) bus ();
  pipe_hazard_ctrl #(.REG_AW(5), .MCYC_LAT(4), .CNT_W(2)) dut (.clk(clk), .rst(rst), .p(bus.slave));
  always #5 clk = ~clk;
  // {pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_en, ex_mem_bubble, mcyc_busy}
  function automatic logic [6:0] ctl();
    return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_bubble, bus.id_ex_en,
            bus.ex_mem_bubble, bus.mcyc_busy};
  endfunction
  task automatic clear();
    {bus.id_rs, bus.id_rt, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.mem_rd, bus.wb_rd} = '0;
    {bus.id_use_rs, bus.id_use_rt, bus.id_branch, bus.id_jr, bus.id_jump, bus.id_taken} = '0;
    {bus.ex_regwrite, bus.ex_memread, bus.ex_mcyc, bus.mem_regwrite, bus.mem_memread, bus.wb_regwrite} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic load_use();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd8;
    bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
  endtask
  task automatic test_reset();
    clear();
    rst = 1'b1;
    #3;
    tests++;
    if (ctl() !== 7'b1100100) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl(), 7'b1100100); end
    tests++;
    if (bus.stall_cnt !== 2'd0 || bus.flush_cnt !== 2'd0) begin
      fails++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_forwarding();
    clear();
    bus.mem_rd = 5'd5; bus.wb_rd = 5'd5; bus.ex_rs = 5'd5; bus.ex_rt = 5'd6;
    bus.mem_regwrite = 1'b1; bus.wb_regwrite = 1'b1;
    #1;
    tests++;
    if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b00) begin
      fails++; $display("FAIL fwd_exmem got %b/%b want 01/00", bus.forward_a, bus.forward_b);
    end
    bus.mem_regwrite = 1'b0; bus.ex_rt = 5'd5;
    #1;
    tests++;
    if (bus.forward_a !== 2'b10 || bus.forward_b !== 2'b10) begin
      fails++; $display("FAIL fwd_wb got %b/%b want 10/10", bus.forward_a, bus.forward_b);
    end
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.ex_rs = 5'd0; bus.ex_rt = 5'd0;
    #1;
    tests++;
    if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin
      fails++; $display("FAIL fwd_r0 got %b/%b want 00/00", bus.forward_a, bus.forward_b);
    end
  endtask
  task automatic test_load_use();
    do_reset();
    load_use();
    #1;
    tests++;
    if (ctl() !== 7'b0001100) begin fails++; $display("FAIL load_use_ctl got %b want %b", ctl(), 7'b0001100); end
    tick();
    clear();
    #1;
    tests++;
    if (ctl() !== 7'b1100100 || bus.stall_cnt !== 2'd1) begin
      fails++; $display("FAIL load_use_after got %b cnt %0d want 1100100 cnt 1", ctl(), bus.stall_cnt);
    end
  endtask
  task automatic test_branch_load();
    do_reset();
    bus.mem_memread = 1'b1; bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd9;
    bus.id_branch = 1'b1; bus.id_rt = 5'd9; bus.id_use_rt = 1'b1;
    #1;
    tests++;
    if (ctl() !== 7'b0001100 || bus.fwd_id_b !== 1'b0) begin
      fails++; $display("FAIL branch_load got %b fwd_id_b %b want 0001100 0", ctl(), bus.fwd_id_b);
    end
    bus.mem_memread = 1'b0;
    #1;
    tests++;
    if (ctl() !== 7'b1100100 || bus.fwd_id_b !== 1'b1 || bus.fwd_id_a !== 1'b0) begin
      fails++; $display("FAIL branch_fwd got %b fwd_id %b%b want 1100100 01", ctl(), bus.fwd_id_a, bus.fwd_id_b);
    end
    bus.mem_regwrite = 1'b0; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd9;
    #1;
    tests++;
    if (ctl() !== 7'b0001100) begin fails++; $display("FAIL branch_ex got %b want %b", ctl(), 7'b0001100); end
  endtask
  task automatic test_taken_branch();
    do_reset();
    bus.id_branch = 1'b1; bus.id_taken = 1'b1;
    #1;
    tests++;
    if (ctl() !== 7'b1110100) begin fails++; $display("FAIL taken_ctl got %b want %b", ctl(), 7'b1110100); end
    tick();
    clear();
    #1;
    tests++;
    if (bus.if_id_flush !== 1'b0 || bus.flush_cnt !== 2'd1 || bus.stall_cnt !== 2'd0) begin
      fails++; $display("FAIL taken_after got flush %b cnt %0d/%0d want 0 1/0", bus.if_id_flush, bus.flush_cnt, bus.stall_cnt);
    end
    bus.id_branch = 1'b1; bus.id_taken = 1'b1;
    load_use();
    #1;
    tests++;
    if (ctl() !== 7'b0001100) begin fails++; $display("FAIL taken_stall got %b want %b", ctl(), 7'b0001100); end
    clear();
    bus.id_jump = 1'b1;
    #1;
    tests++;
    if (bus.if_id_flush !== 1'b1) begin fails++; $display("FAIL jump_flush got %b want 1", bus.if_id_flush); end
  endtask
  task automatic test_mcyc();
    do_reset();
    bus.ex_mcyc = 1'b1;
    #1;
    tests++;
    if (ctl() !== 7'b0000010) begin fails++; $display("FAIL mcyc_c1 got %b want %b", ctl(), 7'b0000010); end
    tick();
    bus.ex_mcyc = 1'b0; bus.id_branch = 1'b1; bus.id_taken = 1'b1;
    #1;
    tests++;
    if (ctl() !== 7'b0000011) begin fails++; $display("FAIL mcyc_c2 got %b want %b", ctl(), 7'b0000011); end
    tick();
    clear();
    load_use();
    bus.ex_rs = 5'd3; bus.wb_rd = 5'd3; bus.wb_regwrite = 1'b1;
    #1;
    tests++;
    if (ctl() !== 7'b0000011 || bus.forward_a !== 2'b10) begin
      fails++; $display("FAIL mcyc_c3 got %b fwd %b want 0000011 10", ctl(), bus.forward_a);
    end
    tick();
    clear();
    #1;
    tests++;
    if (ctl() !== 7'b0000001) begin fails++; $display("FAIL mcyc_c4 got %b want %b", ctl(), 7'b0000001); end
    tick();
    tests++;
    if (ctl() !== 7'b1100100 || bus.stall_cnt !== 2'd3) begin
      fails++; $display("FAIL mcyc_done got %b cnt %0d want 1100100 cnt 3", ctl(), bus.stall_cnt);
    end
  endtask
  task automatic test_mcyc_reset();
    do_reset();
    bus.ex_mcyc = 1'b1;
    tick();
    bus.ex_mcyc = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    tests++;
    if (ctl() !== 7'b1100100 || bus.stall_cnt !== 2'd0) begin
      fails++; $display("FAIL mcyc_abort got %b cnt %0d want 1100100 cnt 0", ctl(), bus.stall_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (ctl() !== 7'b1100100) begin fails++; $display("FAIL mcyc_abort_idle got %b want %b", ctl(), 7'b1100100); end
  endtask
  task automatic test_saturation();
    do_reset();
    load_use();
    tick();
    tick();
    tests++;
    if (bus.stall_cnt !== 2'd2) begin fails++; $display("FAIL sat_mid got %0d want 2", bus.stall_cnt); end
    repeat (4) tick();
    tests++;
    if (bus.stall_cnt !== 2'd3) begin fails++; $display("FAIL sat_end got %0d want 3", bus.stall_cnt); end
    clear();
  endtask
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_load();
    test_taken_branch();
    test_mcyc();
    test_mcyc_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
